// File: rtl/sha256_msg_sequencer.sv
// sha256_msg_sequencer: pads a framed byte stream into 64-byte SHA-256 blocks and forwards the digest.
// Define SHA_SEQ_BLKCNT_EN to add the blk_count output (blocks issued for the current/last message).
module sha256_msg_sequencer #(
  parameter int LEN_W     = 32,
  parameter int DIG_BYTES = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] core_data,
  output logic       core_valid,
  input  logic       core_ready,
  output logic       core_first,
  output logic       core_final,
  input  logic [7:0] core_hash,
  input  logic       core_hash_valid,
  output logic [7:0] hash_out,
  output logic       hash_valid,
  output logic       done,
  output logic       busy,
  output logic       len_ovf
`ifdef SHA_SEQ_BLKCNT_EN
  ,
  output logic [15:0] blk_count
`endif
);
  localparam int HW = $clog2(DIG_BYTES) + 1;
  typedef enum logic [2:0] {IDLE, MSG, PAD80, PADZ, PADLEN, WAITH} state_t;
  state_t state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic len_ovf_q, len_ovf_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [7:0] hash_out_q, hash_out_d;
  logic hash_valid_q, hash_valid_d, done_q, done_d;
  logic [63:0] bit_len;
  logic msg_ph, xfer, acc, beat, start;
  assign bit_len = 64'(len_q) << 3;
  always_comb begin
    msg_ph = state_q == IDLE || state_q == MSG;
    in_ready = msg_ph && core_ready;
    core_valid = msg_ph ? in_valid :
                 (state_q == PAD80 || state_q == PADLEN) ? 1'b1 :
                 (state_q == PADZ) ? idx_q != 6'd56 : 1'b0;
    // Length bytes go out MSB first at block indices 56..63.
    core_data = state_q == PAD80 ? 8'h80 :
                state_q == PADZ ? 8'h00 :
                state_q == PADLEN ? bit_len[{3'd7 - idx_q[2:0], 3'b000} +: 8] : in_data;
    core_first = state_q == IDLE && in_valid;
    core_final = state_q == PADLEN && idx_q == 6'd63;
    xfer = core_valid && core_ready;
    acc = in_valid && in_ready;
    start = acc && state_q == IDLE;
    beat = state_q == WAITH && core_hash_valid;
    idx_d = xfer ? idx_q + 6'd1 : idx_q;
    len_d = start ? LEN_W'(1) : acc ? len_q + LEN_W'(1) : len_q;
    len_ovf_d = start ? 1'b0 : len_ovf_q || (acc && len_q == '1);
    hcnt_d = state_q != WAITH ? '0 : beat ? hcnt_q + HW'(1) : hcnt_q;
    hash_out_d = beat ? core_hash : hash_out_q;
    hash_valid_d = beat;
    done_d = beat && hcnt_q == HW'(DIG_BYTES - 1);
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = acc ? (in_last ? PAD80 : MSG) : IDLE;
      MSG:     state_d = acc && in_last ? PAD80 : MSG;
      PAD80:   state_d = xfer ? PADZ : PAD80;
      PADZ:    state_d = idx_q == 6'd56 ? PADLEN : PADZ;
      PADLEN:  state_d = xfer && idx_q == 6'd63 ? WAITH : PADLEN;
      WAITH:   state_d = done_d ? IDLE : WAITH;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      len_q <= '0;
      len_ovf_q <= 1'b0;
      hcnt_q <= '0;
      hash_out_q <= '0;
      hash_valid_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      len_q <= len_d;
      len_ovf_q <= len_ovf_d;
      hcnt_q <= hcnt_d;
      hash_out_q <= hash_out_d;
      hash_valid_q <= hash_valid_d;
      done_q <= done_d;
    end
  end
  assign hash_out = hash_out_q;
  assign hash_valid = hash_valid_q;
  assign done = done_q;
  assign busy = state_q != IDLE;
  assign len_ovf = len_ovf_q;
`ifdef SHA_SEQ_BLKCNT_EN
  logic [15:0] blk_q, blk_d;
  always_comb begin
    blk_d = start ? 16'd0 : (xfer && idx_q == 6'd63 && blk_q != 16'hFFFF) ? blk_q + 16'd1 : blk_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) blk_q <= '0;
    else blk_q <= blk_d;
  end
  assign blk_count = blk_q;
`endif
endmodule

// File: doc/sha256_msg_sequencer.md
Name: sha256_msg_sequencer

Overview:
Front-end controller for the byte-serial SHA-256 core. It accepts a raw message byte stream with framing, performs SHA-256 padding, and streams complete 64-byte blocks into the core. It flags the first and final blocks so the core chains correctly, then forwards the 32-byte digest to the consumer and pulses done. It sits between the host byte interface and the core's data_in/valid_in port.

Parameters:
LEN_W, 32, width of the message byte counter; bit length = {len, 3'b000} zero-extended to 64 bits
DIG_BYTES, 32, digest beats expected from the core per message

Ports:
clk  in  1  system clock
reset_n  in  1  reset, synchronous, active-low
in_data  in  8  message byte
in_valid  in  1  in_data valid
in_last  in  1  marks final message byte; qualified by in_valid
in_ready  out  1  sequencer accepts in_data this cycle
core_data  out  8  byte to core (drives core data_in)
core_valid  out  1  core_data valid (drives core valid_in)
core_ready  in  1  core accepts byte; low while compressing
core_first  out  1  high with byte 0 of a message's first block
core_final  out  1  high with byte 63 of the message's final block
core_hash  in  8  digest byte from core (hash_out)
core_hash_valid  in  1  digest byte valid (valid_o)
hash_out  out  8  forwarded digest byte
hash_valid  out  1  hash_out valid; no backpressure
done  out  1  one-cycle pulse after last digest byte
busy  out  1  high from first accepted byte until done
len_ovf  out  1  sticky: byte counter wrapped; cleared on next message start

Behaviour:
- Clock clk; reset synchronous, active-low on reset_n, sampled on rising edge. All state and outputs reset to 0: state=IDLE, byte index=0, length=0, len_ovf=0.
- Transfer: a byte moves on core when core_valid && core_ready; on input when in_valid && in_ready.
- Message bytes pass through combinationally: in_ready = core_ready in IDLE/MSG, 0 otherwise; core_valid = in_valid in IDLE/MSG; core_data = in_data. Zero added latency.
- 6-bit block index idx increments per core transfer, wrapping 63->0. Length counter increments per accepted message byte, wrapping mod 2^LEN_W; a wrap sets len_ovf.
- States:
  IDLE: first accepted byte -> core_first=1, busy=1, len=1, len_ovf cleared; in_last ? PAD80 : MSG.
  MSG: each accepted byte len++; accepted with in_last -> PAD80.
  PAD80: emit 0x80 -> PADZ.
  PADZ: emit 0x00 while idx != 56; at idx==56 -> PADLEN without emitting. If the last message byte landed at idx >= 56, zeros run through 63, wrap, and continue to 56 of the next block.
  PADLEN: emit 8 bytes of 64-bit bit-length, MSB first; byte at idx 63 carries core_final=1 -> WAITH.
  WAITH: in_ready=0, core_valid=0; forward each core_hash_valid beat as hash_out/hash_valid with 1-cycle register latency; after the DIG_BYTES-th beat, done=1 next cycle -> IDLE, busy=0.
- Padding outputs are held stable while core_ready=0.
- core_final is asserted only on the final block's byte 63. core_first is asserted only on byte 0 of message.
- Messages are >= 1 byte; a zero-length message is not supported.
- core_hash_valid outside WAITH is ignored.
- Reset mid-message: all state is discarded immediately, no partial padding is emitted, and outputs return to reset values.

Optional Feature:
SHA_SEQ_BLKCNT_EN: when defined, adds output port blk_count[15:0], the number of 64-byte blocks issued to the core for the current or last message. It increments on each idx 63 transfer, clears on message start, and saturates at 0xFFFF. When undefined, the port and counter are absent.

Test Plan:
- "abc" (61 62 63, last on 63), core_ready=1 -> 64 core bytes: 61 62 63 80, zeros at idx 4..55, 00 00 00 00 00 00 00 18; core_first on byte 0, core_final on byte 63.
- 55-byte message -> single block; 0x80 at idx 55; length bytes ...01 B8; exactly 64 transfers.
- 56-byte and 64-byte messages -> 128 transfers each. 56-byte: 0x80 at idx 56, length ...01 C0. 64-byte: 0x80 at byte 64, length ...02 00. core_final only on byte 127.
- core_ready toggled 1/0 every cycle during "abc" padding -> identical byte sequence, in_ready=0 whenever core_ready=0, no duplicated or dropped bytes.
- WAITH with 32 core_hash_valid beats (0x00..0x1F, gaps allowed) -> hash_out 0x00..0x1F, each one cycle later; done pulse once; busy falls; next message core_first=1.
- reset_n low for one cycle mid-PADZ -> next cycle all outputs 0, state IDLE; a new message "a" produces 61 80 ... 00 08.
